hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It drives the stall and flush controls of the fetch, decode, execute, memory and writeback pipeline registers, including the ID/EX control register's `FlushE` input. It also drives the execute-stage operand forwarding muxes. It owns a small state machine that freezes the whole pipeline while a data-memory access waits on `MemReadyM`, and it flags a sticky error if that wait exceeds a bound.

## Interface
Parameters:
- `MEM_TIMEOUT`, 64: maximum consecutive wait cycles before error; range 1–255.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high reset.
- `Rs1D`, `Rs2D` in 5: source registers in decode.
- `Rs1E`, `Rs2E`, `RdE` in 5: source and destination registers in execute.
- `RdM`, `RdW` in 5: destination registers in memory and writeback.
- `RegWriteM`, `RegWriteW` in 1: register write enables in memory and writeback.
- `ResultSrcE` in 2: result select in execute; `2'b01` means a load.
- `PCSrcE` in 1: taken branch or jump resolved in execute.
- `MemReqM` in 1: load or store present in memory stage.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `ForwardAE`, `ForwardBE` out 2: operand select; 00 = RF, 01 = W result, 10 = M ALU result.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW` out 1: hold stage register.
- `FlushD`, `FlushE` out 1: clear stage register to a bubble.
- `MemBusy` out 1: FSM in WAIT.
- `MemErr` out 1: sticky timeout error.
- `StallCycles`, `FlushEvents` out `CNT_W`: present only with `HAZARD_PERF_CNT_EN`.

## Operation
- **Forwarding (combinational).** `ForwardAE` = 10 if `RegWriteM && RdM!=0 && RdM==Rs1E`; else 01 if `RegWriteW && RdW!=0 && RdW==Rs1E`; else 00. `ForwardBE` follows the same rule using `Rs2E`. The M source has priority over W.
- **lwStall** = `ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`.
- **memStall** = `(state==IDLE && MemReqM && !MemReadyM) || (state==WAIT && !MemReadyM) || state==ERR`.
- **FSM states:**
  - IDLE → WAIT when `MemReqM && !MemReadyM`; the wait counter loads 1.
  - WAIT → IDLE when `MemReadyM`; the counter clears.
  - WAIT → ERR when the counter reaches `MEM_TIMEOUT` with `!MemReadyM`; `MemErr` sets.
  - WAIT otherwise increments the counter.
  - ERR is terminal until `reset`.
- **Output priority, highest first:**
  1. `reset`: all Stall outputs = 0, `FlushD` = `FlushE` = 1.
  2. `memStall`: `StallF`–`StallW` = 1, `FlushD` = `FlushE` = 0. The branch held in E re-resolves after release.
  3. `PCSrcE`: `FlushD` = `FlushE` = 1, all Stall outputs = 0. A simultaneous lwStall is suppressed because the D instruction is squashed.
  4. `lwStall`: `StallF` = `StallD` = 1, `FlushE` = 1, everything else 0.
  5. Otherwise all outputs = 0.
- Forwarding outputs are unaffected by stalls. Because W is held, not flushed, during a memory stall, W forwarding stays valid.

## Timing
- All hazard and forwarding outputs are combinational from inputs and current state, and are valid in the same cycle. The pipeline registers act on the next `clk` edge.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 squashed instructions.
- A memory access with `MemReadyM` low for N cycles (N < `MEM_TIMEOUT`) freezes all stages for exactly N cycles. The cycle in which `MemReadyM` rises is not stalled.
- Values after `reset`: state IDLE, wait counter 0, `MemErr` 0, `MemBusy` 0, counters 0. The same applies when `reset` is asserted mid-WAIT or in ERR.
- `MemBusy` and `MemErr` are registered and change one edge after the causing condition.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `StallCycles` increments each non-reset cycle where any Stall output is 1.
  - `FlushEvents` increments each non-reset cycle where `PCSrcE` causes a flush.
  - Both counters wrap modulo 2^`CNT_W`.
- Macro undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Forwarding.** E uses x5 as `Rs1E`; M writes x5 (`RegWriteM`=1) and W also writes x5 → `ForwardAE`=10. With `RdM`=x0 instead → `ForwardAE`=01.
- **Load-use.** Load to x7 in E, x7 as `Rs2D` in D → one cycle of `StallF`=`StallD`=`FlushE`=1, then all outputs 0; no stall when `RdE`=x0.
- **Branch vs load-use.** `PCSrcE`=1 together with lwStall → `FlushD`=`FlushE`=1, `StallF`=`StallD`=0.
- **Memory wait.** `MemReqM`=1 with `MemReadyM` low for 3 cycles → all five Stall outputs 1 for exactly 3 cycles, `MemBusy` 1 from the next edge, state returns to IDLE. With the macro defined, `StallCycles`=3.
- **Timeout.** `MEM_TIMEOUT`=4, `MemReadyM` held low → `MemErr` 1 after the 4th wait cycle, stall persists. `reset` pulsed for 1 cycle → `MemErr`=0, state IDLE, stalls released.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait sequencing for the five-stage RISC-V pipeline.
// Optional performance counters (StallCycles, FlushEvents) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemBusy,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("hazard_ctrl: MEM_TIMEOUT must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_mem_err;
  logic       w_mem_err_nxt;
  logic       w_mem_stall;
  logic       w_lw_stall;

  // M-stage result wins over W-stage result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    w_mem_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt >= TMO) begin
            w_state_nxt   = S_ERR;
            w_mem_err_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
      end
      S_ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Memory freeze beats branch squash, which beats the load-use bubble.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign MemBusy = (r_state == S_WAIT);
  assign MemErr  = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic             w_any_stall;
  logic             w_br_flush;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  assign w_any_stall = StallF | StallD | StallE | StallM | StallW;
  assign w_br_flush  = PCSrcE && !w_mem_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_any_stall)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_br_flush)
        r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushEvents = r_flush_events;
`else
  // Counter ports and state are not built in this configuration.
`endif

endmodule
